// File: rtl/note_sample_sequencer_if.sv
// note_sample_sequencer_if: sine generator request/sample bus.
// master = note sequencer, slave = sine sample generator.
interface note_sample_sequencer_if;
  logic [19:0] step_size;
  logic        sine_generate_next;
  logic [15:0] sine_sample;
  logic        sine_sample_ready;

  modport master (
    output step_size,
    output sine_generate_next,
    input  sine_sample,
    input  sine_sample_ready
  );

  modport slave (
    input  step_size,
    input  sine_generate_next,
    output sine_sample,
    output sine_sample_ready
  );
endinterface

// File: rtl/note_sample_sequencer.sv
// note_sample_sequencer: plays one note, paces sine requests at the codec rate, counts beats.
// Define NOTE_SEQ_OVERRUN_DET_EN to add the overrun_cnt dropped-tick counter.
module note_sample_sequencer #(
  parameter int TIMEOUT = 8,
  parameter int DUR_W   = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             play_enable,
  input  logic             load_new_note,
  input  logic [5:0]       note_to_load,
  input  logic [DUR_W-1:0] duration_to_load,
  input  logic             beat,
  input  logic             generate_next_sample,
  note_sample_sequencer_if.master gen,
  output logic [15:0]      sample_out,
  output logic             new_sample_ready,
  output logic             done_with_note,
  output logic             timeout_err
`ifdef NOTE_SEQ_OVERRUN_DET_EN
  ,
  output logic [7:0]       overrun_cnt
`endif
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  // frequency_rom contents: top-octave equal-tempered steps at 48 kHz, A4 = note 49
  localparam logic [19:0] TOP_OCT [12] = '{
    20'd19224, 20'd20367, 20'd21578, 20'd22861,
    20'd24221, 20'd25661, 20'd27187, 20'd28804,
    20'd30517, 20'd32332, 20'd34254, 20'd36291
  };

  typedef enum logic [1:0] {IDLE, REQ, WAIT, CAPTURE} state_t;

  state_t           state, state_nx;
  logic [5:0]       note_q;
  logic [DUR_W-1:0] dur_q;
  logic             playing;
  logic             rest_q;
  logic [TW-1:0]    timer;
  logic [19:0]      step_q;
  logic [19:0]      rom_d;
  logic [5:0]       idx;
  logic [2:0]       oct;
  logic [3:0]       semi;
  logic             go;
  logic             t_out;

  assign idx   = note_q - 6'd1;
  assign oct   = 3'(idx / 6'd12);
  assign semi  = 4'(idx % 6'd12);
  assign rom_d = (note_q == 6'd0) ? 20'd0 : (TOP_OCT[semi] >> (3'd5 - oct));

  assign go    = generate_next_sample && playing && play_enable;
  assign t_out = (state == WAIT) && !gen.sine_sample_ready && (timer == T_LAST);

  assign gen.step_size          = step_q;
  assign gen.sine_generate_next = (state == REQ) && !rest_q;
  assign new_sample_ready       = (state == CAPTURE);

  always_ff @(posedge clk) begin
    if (reset) begin
      note_q         <= '0;
      dur_q          <= '0;
      playing        <= 1'b0;
      done_with_note <= 1'b0;
      step_q         <= '0;
    end else begin
      done_with_note <= 1'b0;
      step_q         <= rom_d;
      if (load_new_note) begin
        note_q         <= note_to_load;
        dur_q          <= duration_to_load;
        playing        <= |duration_to_load;
        done_with_note <= ~|duration_to_load;
      end else if (beat && playing && play_enable) begin
        dur_q <= dur_q - DUR_W'(1);
        if (dur_q == DUR_W'(1)) begin
          playing        <= 1'b0;
          done_with_note <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // rests pass through REQ with the request masked so they share slot timing
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (go) state_nx = REQ;
      REQ:     state_nx = rest_q ? CAPTURE : WAIT;
      WAIT:    if (gen.sine_sample_ready || t_out) state_nx = CAPTURE;
      CAPTURE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rest_q      <= 1'b0;
      timer       <= '0;
      sample_out  <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == IDLE && go) rest_q <= (note_q == 6'd0);
      if (state == REQ)       timer <= '0;
      else if (state == WAIT) timer <= timer + 1'b1;
      if (state == REQ && rest_q)
        sample_out <= '0;
      else if (state == WAIT && gen.sine_sample_ready)
        sample_out <= gen.sine_sample;
      else if (t_out)
        sample_out <= '0;
      if (t_out)              timeout_err <= 1'b1;
      else if (load_new_note) timeout_err <= 1'b0;
    end
  end

`ifdef NOTE_SEQ_OVERRUN_DET_EN
  always_ff @(posedge clk) begin
    if (reset)
      overrun_cnt <= '0;
    else if (go && state != IDLE && overrun_cnt != 8'hFF)
      overrun_cnt <= overrun_cnt + 8'd1;
  end
`endif

endmodule
